// File: rtl/udp_pkg.sv
// udp_pkg: shared types for the UDP receive path.
// Read-FSM one-hot encodings and last-word keep decode.
package udp_pkg;

  localparam int BN_W = 16;
  localparam int DW   = 32;

  localparam int S_IDLE  = 0;
  localparam int S_FETCH = 1;
  localparam int S_SEND  = 2;

  typedef enum logic [2:0] {
    RD_IDLE  = 3'b001,
    RD_FETCH = 3'b010,
    RD_SEND  = 3'b100
  } rd_state_t;

  function automatic logic [3:0] keep_lut(
    input logic [1:0] rem
  );
    logic [3:0] k;
    unique case (rem)
      2'd0:    k = 4'b1111;
      2'd1:    k = 4'b1000;
      2'd2:    k = 4'b1100;
      default: k = 4'b1110;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// sdp_ram: simple dual-port RAM, one write port and
// one registered read port, for block-RAM inference.
module sdp_ram #(
  parameter int AW = 9,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // write port and synchronous read port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/udp_rx_pkt_buf.sv
// udp_rx_pkt_buf: store-and-forward payload buffer
// from the UDP receiver to a valid/ready stream.
module udp_rx_pkt_buf
  import udp_pkg::*;
#(
  parameter int ADDR_W     = 9,
  parameter int LEN_FIFO_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rec_en,
  input  logic [DW-1:0]   rec_data,
  input  logic            rec_pkt_done,
  input  logic [BN_W-1:0] rec_byte_num,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [DW-1:0]   m_data,
  output logic [3:0]      m_keep,
  output logic            m_last,
  output logic [BN_W-1:0] m_byte_num,
  output logic [BN_W-1:0] drop_cnt
);

  localparam int PW = ADDR_W + 1;
  localparam int FD = 1 << LEN_FIFO_W;
  localparam int CW = (PW > 17) ? PW : 17;

  typedef logic [PW-1:0]         ptr_t;
  typedef logic [CW-1:0]         cnt_t;
  typedef logic [LEN_FIFO_W-1:0] fidx_t;
  typedef logic [LEN_FIFO_W:0]   fcnt_t;
  typedef logic [LEN_FIFO_W+1:0] occ_t;

  localparam ptr_t RAM_WORDS = ptr_t'(1 << ADDR_W);
  localparam ptr_t ONE       = ptr_t'(1);

  ptr_t wr_ptr, wr_commit, wr_nx, rd_ptr, rd_nx;
  ptr_t used, pkt_words, rem;
  logic [16:0] need;
  logic ovf, ovf_now, ram_full, wr_go, commit;
  logic desc_full, busy, rd_fire, pop, f_nempty;
  logic is_last;
  occ_t occ;
  logic [BN_W-1:0] drop_q, bn_q;

  logic [BN_W-1:0] fifo_bn [FD];
  ptr_t            fifo_wc [FD];
  fidx_t f_wr, f_rd;
  fcnt_t f_cnt;

  rd_state_t state, state_nx;
  logic [DW-1:0]     ram_q;
  logic [ADDR_W-1:0] raddr;

  assign busy     = (state != RD_IDLE);
  assign rd_fire  = (state == RD_SEND) && m_ready;
  assign f_nempty = (f_cnt != '0);
  assign is_last  = (rem == ONE);
  assign rd_nx    = rd_ptr + ONE;
  assign raddr    = rd_fire ? rd_nx[ADDR_W-1:0]
                            : rd_ptr[ADDR_W-1:0];

  // write-side admission and commit decision
  always_comb begin
    used      = wr_ptr - rd_ptr;
    ram_full  = (used == RAM_WORDS) && !rd_fire;
    wr_go     = rec_en && !ovf && !ram_full;
    ovf_now   = ovf || (rec_en && ram_full);
    wr_nx     = wr_ptr + (wr_go ? ONE : '0);
    pkt_words = wr_nx - wr_commit;
    need      = (17'(rec_byte_num) + 17'd3) >> 2;
    occ       = occ_t'(f_cnt) + (busy ? occ_t'(1) : '0);
    desc_full = (occ >= occ_t'(FD));
    commit    = rec_pkt_done && !ovf_now && !desc_full
             && (rec_byte_num != '0)
             && (cnt_t'(pkt_words) == cnt_t'(need));
  end

  // write pointer, commit point, overflow and drops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      wr_commit <= '0;
      ovf       <= 1'b0;
      drop_q    <= '0;
    end else if (rec_pkt_done) begin
      ovf <= 1'b0;
      if (commit) begin
        wr_ptr    <= wr_nx;
        wr_commit <= wr_nx;
      end else begin
        wr_ptr <= wr_commit;
        if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      end
    end else begin
      wr_ptr <= wr_nx;
      if (rec_en && ram_full) ovf <= 1'b1;
    end
  end

  // descriptor FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_wr  <= '0;
      f_rd  <= '0;
      f_cnt <= '0;
    end else begin
      if (commit) f_wr <= f_wr + fidx_t'(1);
      if (pop)    f_rd <= f_rd + fidx_t'(1);
      if (commit && !pop)      f_cnt <= f_cnt + fcnt_t'(1);
      else if (!commit && pop) f_cnt <= f_cnt - fcnt_t'(1);
    end
  end

  // descriptor FIFO storage
  always_ff @(posedge clk) begin
    if (commit) begin
      fifo_bn[f_wr] <= rec_byte_num;
      fifo_wc[f_wr] <= pkt_words;
    end
  end

  // read FSM state, read pointer and packet context
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= RD_IDLE;
      rd_ptr <= '0;
      rem    <= '0;
      bn_q   <= '0;
    end else begin
      state <= state_nx;
      if (rd_fire) begin
        rd_ptr <= rd_nx;
        rem    <= rem - ONE;
      end
      if (pop) begin
        bn_q <= fifo_bn[f_rd];
        rem  <= fifo_wc[f_rd];
      end
    end
  end

  // read FSM next state and descriptor pop
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    unique case (1'b1)
      state[S_IDLE]: begin
        if (f_nempty) begin
          pop      = 1'b1;
          state_nx = RD_FETCH;
        end
      end
      state[S_FETCH]: state_nx = RD_SEND;
      state[S_SEND]: begin
        if (rd_fire && is_last) begin
          if (f_nempty) begin
            pop      = 1'b1;
            state_nx = RD_FETCH;
          end else begin
            state_nx = RD_IDLE;
          end
        end
      end
      default: state_nx = RD_IDLE;
    endcase
  end

  sdp_ram #(
    .AW(ADDR_W),
    .DW(DW)
  ) u_ram (
    .clk  (clk),
    .we   (wr_go),
    .waddr(wr_ptr[ADDR_W-1:0]),
    .wdata(rec_data),
    .raddr(raddr),
    .rdata(ram_q)
  );

  assign m_valid    = (state == RD_SEND);
  assign m_data     = m_valid ? ram_q : '0;
  assign m_last     = m_valid && is_last;
  assign m_keep     = !m_valid ? 4'b0000
                    : is_last ? keep_lut(bn_q[1:0])
                    : 4'b1111;
  assign m_byte_num = bn_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_udp_rx_pkt_buf.sv
// tb_udp_rx_pkt_buf: scenario bench for udp_rx_pkt_buf
// with a packet-level reference model.
module tb_udp_rx_pkt_buf;

  localparam int AW    = 4;
  localparam int WORDS = 1 << AW;

  typedef logic [52:0]     beat_t;
  typedef logic [7:0]      bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rec_en = 1'b0;
  logic [31:0] rec_data = '0;
  logic        rec_pkt_done = 1'b0;
  logic [15:0] rec_byte_num = '0;
  logic        m_ready = 1'b0;
  logic        m_valid, m_last;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic [15:0] m_byte_num, drop_cnt;

  int checks = 0;
  int failures = 0;
  int valid_seen = 0;
  int stall_seen = 0;
  int stall_viol = 0;
  int exp_drop = 0;
  beat_t rx[$];
  beat_t exp_q[$];
  logic  prev_stall = 1'b0;
  beat_t prev_beat = '0;

  always #5 clk = ~clk;

  udp_rx_pkt_buf #(
    .ADDR_W(AW),
    .LEN_FIFO_W(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rec_en      (rec_en),
    .rec_data    (rec_data),
    .rec_pkt_done(rec_pkt_done),
    .rec_byte_num(rec_byte_num),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_keep      (m_keep),
    .m_last      (m_last),
    .m_byte_num  (m_byte_num),
    .drop_cnt    (drop_cnt)
  );

  // output monitor: records accepted beats, stall stability
  always @(negedge clk) begin
    beat_t cur;
    cur = {m_data, m_keep, m_last, m_byte_num};
    if (prev_stall && (!m_valid || cur !== prev_beat))
      stall_viol++;
    if (m_valid) valid_seen++;
    if (m_valid && !m_ready) stall_seen++;
    if (m_valid && m_ready) rx.push_back(cur);
    prev_stall = m_valid && !m_ready && rst_n;
    prev_beat  = cur;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rec_en = 1'b0;
    rec_pkt_done = 1'b0;
    rec_data = '0;
    m_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    exp_drop = 0;
    tick();
  endtask

  // reference: expected beats of one accepted packet
  task automatic model_pkt(input bq_t b, input int bnum);
    int nw;
    int r;
    logic [31:0] d;
    logic [3:0] k;
    nw = (bnum + 3) / 4;
    r = bnum % 4;
    for (int w = 0; w < nw; w++) begin
      d = '0;
      for (int j = 0; j < 4; j++)
        if (4*w + j < b.size()) d[31-8*j -: 8] = b[4*w+j];
      k = 4'hF;
      if (w == nw-1 && r != 0) k = k << (4 - r);
      exp_q.push_back({d, k, (w == nw-1), 16'(bnum)});
    end
  endtask

  task automatic send_pkt(input bq_t b, input int bnum,
                          input int nw, input int gap);
    logic [31:0] d;
    for (int w = 0; w < nw; w++) begin
      d = '0;
      for (int j = 0; j < 4; j++)
        if (4*w + j < b.size()) d[31-8*j -: 8] = b[4*w+j];
      if (gap > 0) repeat ($urandom_range(gap, 0)) tick();
      rec_en = 1'b1;
      rec_data = d;
      rec_pkt_done = (w == nw-1);
      rec_byte_num = (w == nw-1) ? 16'(bnum) : 16'($urandom);
      tick();
      rec_en = 1'b0;
      rec_pkt_done = 1'b0;
      rec_data = '0;
    end
  endtask

  task automatic drain(input int mode, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      case (mode)
        0: m_ready = 1'b1;
        1: m_ready = ~m_ready;
        default: m_ready = ($urandom_range(3, 0) != 0);
      endcase
      tick();
    end
  endtask

  function automatic bq_t rand_bytes(input int n);
    bq_t b;
    for (int i = 0; i < n; i++) b.push_back(8'($urandom));
    return b;
  endfunction

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (m_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_valid got=%b want=0", m_valid);
    end
    if (m_last !== 1'b0) begin
      failures++;
      $display("FAIL rst_last got=%b want=0", m_last);
    end
    if (m_keep !== 4'h0) begin
      failures++;
      $display("FAIL rst_keep got=%h want=0", m_keep);
    end
    if (m_data !== 32'h0) begin
      failures++;
      $display("FAIL rst_data got=%h want=0", m_data);
    end
    if (m_byte_num !== 16'h0) begin
      failures++;
      $display("FAIL rst_bnum got=%h want=0", m_byte_num);
    end
    if (drop_cnt !== 16'h0) begin
      failures++;
      $display("FAIL rst_drop got=%0d want=0", drop_cnt);
    end
  endtask

  task automatic test_8byte();
    bq_t b;
    int lat;
    rx.delete();
    exp_q.delete();
    for (int i = 0; i < 8; i++) b.push_back(8'(i + 1));
    m_ready = 1'b1;
    model_pkt(b, 8);
    send_pkt(b, 8, 2, 0);
    lat = 0;
    while (!m_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (!m_valid || lat > 3) begin
      failures++;
      $display("FAIL b8_latency got=%0d want<=3", lat);
    end
    drain(0, 10);
    checks++;
    if (rx.size() != 2) begin
      failures++;
      $display("FAIL b8_count got=%0d want=2", rx.size());
    end
    foreach (exp_q[i]) if (i < rx.size()) begin
      checks++;
      if (rx[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL b8_beat%0d got=%h want=%h",
                 i, rx[i], exp_q[i]);
      end
    end
    if (rx.size() == 2) begin
      checks++;
      if (rx[1] !== {32'h05060708, 4'hF, 1'b1, 16'd8}) begin
        failures++;
        $display("FAIL b8_last got=%h want=%h", rx[1],
                 {32'h05060708, 4'hF, 1'b1, 16'd8});
      end
    end
  endtask

  task automatic test_5byte();
    bq_t b;
    rx.delete();
    exp_q.delete();
    b = rand_bytes(5);
    m_ready = 1'b1;
    model_pkt(b, 5);
    send_pkt(b, 5, 2, 1);
    drain(0, 12);
    checks++;
    if (rx.size() != 2) begin
      failures++;
      $display("FAIL b5_count got=%0d want=2", rx.size());
    end
    foreach (exp_q[i]) if (i < rx.size()) begin
      checks++;
      if (rx[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL b5_beat%0d got=%h want=%h",
                 i, rx[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_overflow();
    bq_t b;
    int vs0;
    rx.delete();
    exp_q.delete();
    m_ready = 1'b1;
    vs0 = valid_seen;
    b = rand_bytes(68);
    send_pkt(b, 68, 17, 0);
    exp_drop++;
    drain(0, 10);
    checks += 2;
    if (drop_cnt !== 16'(exp_drop)) begin
      failures++;
      $display("FAIL ovf_drop got=%0d want=%0d", drop_cnt, exp_drop);
    end
    if (valid_seen != vs0) begin
      failures++;
      $display("FAIL ovf_novalid got=%0d want=0", valid_seen - vs0);
    end
    b = rand_bytes(4);
    model_pkt(b, 4);
    send_pkt(b, 4, 1, 0);
    drain(0, 10);
    checks++;
    if (rx.size() != 1) begin
      failures++;
      $display("FAIL ovf_next_count got=%0d want=1", rx.size());
    end
    foreach (exp_q[i]) if (i < rx.size()) begin
      checks++;
      if (rx[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL ovf_next got=%h want=%h", rx[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bq_t b;
    rx.delete();
    exp_q.delete();
    m_ready = 1'b0;
    for (int p = 0; p < 5; p++) begin
      b = rand_bytes(4);
      if (p < 4) model_pkt(b, 4);
      send_pkt(b, 4, 1, 0);
    end
    exp_drop++;
    repeat (4) tick();
    checks += 2;
    if (drop_cnt !== 16'(exp_drop)) begin
      failures++;
      $display("FAIL b2b_drop got=%0d want=%0d", drop_cnt, exp_drop);
    end
    if (rx.size() != 0) begin
      failures++;
      $display("FAIL b2b_early got=%0d want=0", rx.size());
    end
    drain(0, 30);
    checks++;
    if (rx.size() != 4) begin
      failures++;
      $display("FAIL b2b_count got=%0d want=4", rx.size());
    end
    foreach (exp_q[i]) if (i < rx.size()) begin
      checks++;
      if (rx[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL b2b_pkt%0d got=%h want=%h",
                 i, rx[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_stall_toggle();
    bq_t b;
    rx.delete();
    exp_q.delete();
    m_ready = 1'b0;
    b = rand_bytes(40);
    model_pkt(b, 40);
    send_pkt(b, 40, 10, 0);
    stall_viol = 0;
    stall_seen = 0;
    drain(1, 40);
    checks += 3;
    if (rx.size() != 10) begin
      failures++;
      $display("FAIL tog_count got=%0d want=10", rx.size());
    end
    if (stall_viol != 0) begin
      failures++;
      $display("FAIL tog_stable got=%0d want=0", stall_viol);
    end
    if (stall_seen == 0) begin
      failures++;
      $display("FAIL tog_stalls got=0 want>0");
    end
    foreach (exp_q[i]) if (i < rx.size()) begin
      checks++;
      if (rx[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL tog_beat%0d got=%h want=%h",
                 i, rx[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    bq_t b;
    int vs0;
    rx.delete();
    exp_q.delete();
    m_ready = 1'b1;
    for (int w = 0; w < 3; w++) begin
      rec_en = 1'b1;
      rec_data = $urandom;
      tick();
    end
    rec_en = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_drop = 0;
    vs0 = valid_seen;
    drain(0, 10);
    checks += 2;
    if (valid_seen != vs0) begin
      failures++;
      $display("FAIL mrst_novalid got=%0d want=0", valid_seen - vs0);
    end
    if (drop_cnt !== 16'd0) begin
      failures++;
      $display("FAIL mrst_drop got=%0d want=0", drop_cnt);
    end
    b = rand_bytes(11);
    model_pkt(b, 11);
    send_pkt(b, 11, 3, 0);
    drain(0, 12);
    checks++;
    if (rx.size() != 3) begin
      failures++;
      $display("FAIL mrst_count got=%0d want=3", rx.size());
    end
    foreach (exp_q[i]) if (i < rx.size()) begin
      checks++;
      if (rx[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL mrst_beat%0d got=%h want=%h",
                 i, rx[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    bq_t b;
    int len, bnum, nw, kind;
    bit acc;
    rx.delete();
    exp_q.delete();
    for (int p = 0; p < 30; p++) begin
      len  = $urandom_range(80, 1);
      kind = $urandom_range(5, 0);
      b    = rand_bytes(len);
      bnum = len;
      nw   = (len + 3) / 4;
      if (kind == 1) bnum = 0;
      if (kind == 2) nw = nw + 1;
      acc = (bnum != 0) && (nw == (bnum + 3) / 4)
         && (nw <= WORDS);
      if (acc) model_pkt(b, bnum);
      else exp_drop++;
      send_pkt(b, bnum, nw, 2);
      drain(2, 120);
    end
    checks += 2;
    if (rx.size() != exp_q.size()) begin
      failures++;
      $display("FAIL rnd_count got=%0d want=%0d",
               rx.size(), exp_q.size());
    end
    if (drop_cnt !== 16'(exp_drop)) begin
      failures++;
      $display("FAIL rnd_drop got=%0d want=%0d", drop_cnt, exp_drop);
    end
    foreach (exp_q[i]) if (i < rx.size()) begin
      checks++;
      if (rx[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL rnd_beat%0d got=%h want=%h",
                 i, rx[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_8byte();
    test_5byte();
    test_overflow();
    test_back_to_back();
    test_stall_toggle();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
